// File: rtl/pause_ctrl_multi.sv
// pause_ctrl_multi: merges menu flag and maskable pause requests into a vblank-aligned core pause with frame stepping; optional dimming via PAUSE_DIM_EN.
module pause_ctrl_multi #(
   parameter int          NUM_REQ     = 4,
   parameter int          SYNC_STAGES = 2,
   parameter logic [23:0] DIM_TIMEOUT = 24'd6_000_000
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               os_inmenu,
   input  logic [NUM_REQ-1:0] pause_req,
   input  logic [NUM_REQ-1:0] req_mask,
   input  logic               vblank,
   input  logic               align_en,
   input  logic               step,
   output logic               pause_core,
   output logic [NUM_REQ:0]   src_active,
   output logic               dim_video
);
   typedef enum logic [2:0] {RUN, WAIT_IN, PAUSED, WAIT_OUT, STEP} state_t;
   state_t state, nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic [NUM_REQ-1:0] req_eff;
   logic vblank_d, step_d, inmenu_s, req_any, vbl_rise, stp_rise;
   assign inmenu_s = sync[SYNC_STAGES-1];
   assign req_eff  = pause_req & ~req_mask;
   assign req_any  = inmenu_s | (|req_eff);
   assign vbl_rise = vblank & ~vblank_d;
   assign stp_rise = step & ~step_d;
   always_comb begin
      nxt = state;
      case (state)
         RUN:      nxt = req_any ? (align_en ? WAIT_IN : PAUSED) : RUN;
         WAIT_IN:  nxt = !req_any ? RUN : vbl_rise ? PAUSED : WAIT_IN;
         PAUSED:   nxt = !req_any ? (align_en ? WAIT_OUT : RUN) : stp_rise ? STEP : PAUSED;
         WAIT_OUT: nxt = req_any ? PAUSED : vbl_rise ? RUN : WAIT_OUT;
         STEP:     nxt = vbl_rise ? (req_any ? PAUSED : RUN) : STEP;
         default:  nxt = RUN;
      endcase
   end
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RUN;
         sync       <= '0;
         vblank_d   <= 1'b0;
         step_d     <= 1'b0;
         pause_core <= 1'b0;
         src_active <= '0;
      end else begin
         state      <= nxt;
         sync       <= {sync[SYNC_STAGES-2:0], os_inmenu};
         vblank_d   <= vblank;
         step_d     <= step;
         pause_core <= (nxt == PAUSED) || (nxt == WAIT_OUT);
         src_active <= {inmenu_s, req_eff};
      end
   end
`ifdef PAUSE_DIM_EN
   localparam int CW = $clog2(DIM_TIMEOUT + 1);
   localparam logic [CW-1:0] DIM_MAX = CW'(DIM_TIMEOUT);
   logic [CW-1:0] dim_cnt;
   logic dim_clr;
   // WAIT_OUT keeps the dim state so a cancelled exit resumes where it was
   assign dim_clr = (nxt == RUN) || (nxt == WAIT_IN) || (nxt == STEP);
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dim_cnt   <= '0;
         dim_video <= 1'b0;
      end else begin
         dim_cnt   <= dim_clr ? '0 : (state == PAUSED && nxt == PAUSED && dim_cnt != DIM_MAX) ? dim_cnt + 1'b1 : dim_cnt;
         dim_video <= dim_clr ? 1'b0 : (dim_cnt == DIM_MAX);
      end
   end
`else
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) dim_video <= 1'b0;
      else          dim_video <= 1'b0 & (DIM_TIMEOUT == '0);
   end
`endif
endmodule

// File: tb/tb_pause_ctrl_multi.sv
// tb_pause_ctrl_multi: directed vector table plus menu-latency and async-reset sequences for pause_ctrl_multi.
module tb_pause_ctrl_multi;
   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   logic os_inmenu = 1'b0;
   logic [3:0] pause_req = '0;
   logic [3:0] req_mask = '0;
   logic vblank = 1'b0;
   logic align_en = 1'b0;
   logic step = 1'b0;
   logic pause_core;
   logic [4:0] src_active;
   logic dim_video;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic [3:0] req;
      logic [3:0] mask;
      logic       align;
      logic       vbl;
      logic       stp;
      logic       pc;
      logic [4:0] src;
   } vec_t;
   vec_t v[$];
   pause_ctrl_multi dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .os_inmenu(os_inmenu),
      .pause_req(pause_req), .req_mask(req_mask), .vblank(vblank),
      .align_en(align_en), .step(step), .pause_core(pause_core),
      .src_active(src_active), .dim_video(dim_video)
   );
   always #5 clk_sys = ~clk_sys;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask
   initial begin
      v.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000});
      v.push_back('{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00010});
      v.push_back('{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00010});
      v.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000});
      v.push_back('{4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000});
      v.push_back('{4'b0101, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00001});
      v.push_back('{4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000});
      v.push_back('{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00001});
      v.push_back('{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00001});
      v.push_back('{4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00001});
      v.push_back('{4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00001});
      v.push_back('{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00001});
      v.push_back('{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00001});
      v.push_back('{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00001});
      v.push_back('{4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00001});
      v.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00000});
      v.push_back('{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000});
      v.push_back('{4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010});
      v.push_back('{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000});
      v.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000});
      v.push_back('{4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'b01000});
      v.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00000});
      v.push_back('{4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 5'b01000});
      v.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000});
      v.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000});
      v.push_back('{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00010});
      v.push_back('{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00010});
      v.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000});
      tick();
      tick();
      chk("reset_pause_core", 32'(pause_core), 32'd0);
      chk("reset_src_active", 32'(src_active), 32'd0);
      chk("reset_dim_video", 32'(dim_video), 32'd0);
      reset_n = 1'b1;
      foreach (v[i]) begin
         pause_req = v[i].req;
         req_mask  = v[i].mask;
         align_en  = v[i].align;
         vblank    = v[i].vbl;
         step      = v[i].stp;
         tick();
         chk($sformatf("vec%0d_pause_core", i), 32'(pause_core), 32'(v[i].pc));
         chk($sformatf("vec%0d_src_active", i), 32'(src_active), 32'(v[i].src));
         chk($sformatf("vec%0d_dim_video", i), 32'(dim_video), 32'd0);
      end
      #2 os_inmenu = 1'b1;
      tick();
      chk("menu_edge1_pause_core", 32'(pause_core), 32'd0);
      tick();
      chk("menu_edge2_pause_core", 32'(pause_core), 32'd0);
      tick();
      chk("menu_edge3_pause_core", 32'(pause_core), 32'd1);
      chk("menu_edge3_src_active", 32'(src_active), 32'b10000);
      #3 os_inmenu = 1'b0;
      begin
         int n = 0;
         while (pause_core !== 1'b0 && n < 10) begin
            tick();
            n++;
         end
         chk("menu_release_latency", 32'(n), 32'd3);
      end
      align_en  = 1'b1;
      pause_req = 4'b0010;
      tick();
      chk("waitin_pause_core", 32'(pause_core), 32'd0);
      chk("waitin_src_active", 32'(src_active), 32'b00010);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_pause_core", 32'(pause_core), 32'd0);
      chk("async_reset_src_active", 32'(src_active), 32'd0);
      chk("async_reset_dim_video", 32'(dim_video), 32'd0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
